// File: rtl/synth_pkg.sv
// Shared types and widths for the synthesizer voice path.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_PULSE  = 2'd3
    } wave_t;

    localparam int PHASE_W  = 8;
    localparam int SAMPLE_W = 8;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample shaper; shared by the tone generator and the LFO.
module wave_shaper
    import synth_pkg::*;
(
    input  logic [PHASE_W-1:0]  phase,
    input  wave_t               wave,
    output logic [SAMPLE_W-1:0] sample
);

    // Map the phase onto the selected waveform (all unsigned, full scale 0..255)
    always_comb begin
        sample = '0;
        unique case (wave)
            WAVE_SQUARE: sample = phase[7] ? '0 : '1;
            WAVE_SAW:    sample = phase;
            WAVE_TRI:    sample = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
            WAVE_PULSE:  sample = (phase[7:6] == 2'b00) ? '1 : '0;
        endcase
    end

endmodule

// File: rtl/wave_gen.sv
// Tone generator: prescaler, 8-bit phase accumulator, glitch-free wave switching
// at phase wrap, registered sample output for the mixer/PWM stage.
module wave_gen
    import synth_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wave_sel,
    input  logic             wave_sel_valid,
    input  logic [DIV_W-1:0] divider,
    output logic [7:0]       sample,
    output logic             sample_strobe,
    output logic [1:0]       active_wave,
    output logic             wrap
);

    localparam logic [DIV_W-1:0]   DIV_ONE   = 1;
    localparam logic [PHASE_W-1:0] PHASE_ONE = 1;

    logic [DIV_W-1:0]    div_cnt;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  phase_inc;
    logic                pending_flag;
    wave_t               pending_sel;
    wave_t               active_q;
    wave_t               wave_in;
    wave_t               req_next;
    wave_t               wave_next;
    logic                mute;
    logic                step;
    logic                wrap_step;
    logic [SAMPLE_W-1:0] shaped;

    assign wave_in     = wave_t'(wave_sel);
    assign active_wave = active_q;
    assign mute        = (divider == '0);
    // >= rather than == so a divider lowered below the running count steps at once
    assign step        = !mute && (div_cnt >= (divider - DIV_ONE));
    assign wrap_step   = step && (phase == '1);
    assign phase_inc   = phase + PHASE_ONE;

    // Wave type to adopt at a switch point; a same-cycle request beats the pending one
    always_comb begin
        req_next = active_q;
        if (wave_sel_valid) begin
            req_next = wave_in;
        end else if (pending_flag) begin
            req_next = pending_sel;
        end
        wave_next = wrap_step ? req_next : active_q;
    end

    wave_shaper u_shaper (
        .phase  (phase_inc),
        .wave   (wave_next),
        .sample (shaped)
    );

    // Prescaler, phase accumulator, request register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            phase         <= '0;
            pending_flag  <= 1'b0;
            pending_sel   <= WAVE_SQUARE;
            active_q      <= WAVE_SQUARE;
            sample        <= '0;
            sample_strobe <= 1'b0;
            wrap          <= 1'b0;
        end else if (mute) begin
            // No phase is running, so any request can be applied immediately
            div_cnt       <= '0;
            phase         <= '0;
            sample        <= '0;
            sample_strobe <= 1'b0;
            wrap          <= 1'b0;
            active_q      <= req_next;
            pending_flag  <= 1'b0;
        end else begin
            sample_strobe <= step;
            wrap          <= wrap_step;
            if (step) begin
                div_cnt <= '0;
                phase   <= phase_inc;
                sample  <= shaped;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end
            if (wrap_step) begin
                active_q     <= wave_next;
                pending_flag <= 1'b0;
            end else if (wave_sel_valid) begin
                pending_sel  <= wave_in;
                pending_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: cycle model plus directed literal checks.
module tb_wave_gen;
    import synth_pkg::*;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       wave_sel = 2'd0;
    logic             wave_sel_valid = 1'b0;
    logic [DIV_W-1:0] divider = 16'd4;
    logic [7:0]       sample;
    logic             sample_strobe;
    logic [1:0]       active_wave;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wave_gen #(.DIV_W(DIV_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .wave_sel       (wave_sel),
        .wave_sel_valid (wave_sel_valid),
        .divider        (divider),
        .sample         (sample),
        .sample_strobe  (sample_strobe),
        .active_wave    (active_wave),
        .wrap           (wrap)
    );

    // Waveform definitions in plain arithmetic
    function automatic int shape_f(int p, int w);
        case (w)
            0:       return (p < 128) ? 255 : 0;
            1:       return p;
            2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            default: return (p < 64) ? 255 : 0;
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt = 0, m_phase = 0, m_ps = 0, m_act = 0, m_samp = 0;
    bit m_pf = 0, m_strobe = 0, m_wrap = 0;
    int m_req;
    bit m_isstep, m_iswrap;

    assign m_req    = wave_sel_valid ? int'(wave_sel) : (m_pf ? m_ps : m_act);
    assign m_isstep = (divider != 0) && (m_cnt + 1 >= int'(divider));
    assign m_iswrap = m_isstep && (m_phase == 255);

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0; m_phase <= 0; m_pf <= 0; m_ps <= 0; m_act <= 0;
            m_samp <= 0; m_strobe <= 0; m_wrap <= 0;
        end else if (divider == 0) begin
            m_cnt <= 0; m_phase <= 0; m_samp <= 0; m_strobe <= 0; m_wrap <= 0;
            m_act <= m_req; m_pf <= 0;
        end else begin
            m_strobe <= m_isstep;
            m_wrap   <= m_iswrap;
            if (m_isstep) begin
                m_cnt   <= 0;
                m_phase <= (m_phase + 1) % 256;
                m_samp  <= shape_f((m_phase + 1) % 256, m_iswrap ? m_req : m_act);
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (m_iswrap) begin
                m_act <= m_req;
                m_pf  <= 0;
            end else if (wave_sel_valid) begin
                m_pf <= 1;
                m_ps <= int'(wave_sel);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_sample", int'(sample), m_samp);
        chk("m_strobe", int'(sample_strobe), int'(m_strobe));
        chk("m_wrap", int'(wrap), int'(m_wrap));
        chk("m_active", int'(active_wave), m_act);
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic pulse(input logic [1:0] w);
        wave_sel = w;
        wave_sel_valid = 1'b1;
        @(negedge clk);
        wave_sel_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_strobe && n < 64);
        if (!sample_strobe) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: got no strobe required one within 64 cycles");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int p;

        // 1. reset
        rst = 1'b1;
        divider = 16'd4;
        repeat (2) @(negedge clk);
        chk("rst_sample", int'(sample), 0);
        chk("rst_strobe", int'(sample_strobe), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_active", int'(active_wave), 0);

        // 2. SAW requested during mute, then run at divider 4
        rst = 1'b0;
        divider = 16'd0;
        pulse(2'd1);
        chk("mute_req_saw", int'(active_wave), 1);
        divider = 16'd4;
        for (int k = 1; k <= 256; k++) begin
            wait_strobe(n);
            chk("saw_period", n, 4);
            chk("saw_sample", int'(sample), k % 256);
            chk("saw_wrap", int'(wrap), (k == 256) ? 1 : 0);
        end

        // 3. triangle at divider 1
        divider = 16'd0;
        pulse(2'd2);
        chk("mute_req_tri", int'(active_wave), 2);
        divider = 16'd1;
        for (int k = 1; k <= 256; k++) begin
            wait_strobe(n);
            p = k % 256;
            if (p == 64)  chk("tri_64", int'(sample), 128);
            if (p == 127) chk("tri_127", int'(sample), 254);
            if (p == 128) chk("tri_128", int'(sample), 255);
            if (p == 192) chk("tri_192", int'(sample), 127);
            if (p == 0)   chk("tri_0", int'(sample), 0);
        end

        // 4. mid-period requests while running SAW; last one wins at the wrap
        divider = 16'd0;
        pulse(2'd1);
        divider = 16'd2;
        for (int k = 1; k <= 256; k++) begin
            wait_strobe(n);
            p = k % 256;
            if (p == 255) chk("midchg_still_saw", int'(active_wave), 1);
            if (p == 0) begin
                chk("midchg_wrap_sample", int'(sample), 255);
                chk("midchg_active", int'(active_wave), 3);
                chk("midchg_wrap", int'(wrap), 1);
            end
            if (p == 100) pulse(2'd2);
            if (p == 200) pulse(2'd3);
        end

        // 5. request coincident with the wrapping step
        for (int k = 1; k <= 255; k++) wait_strobe(n);
        chk("sim_pre_active", int'(active_wave), 3);
        @(negedge clk);
        wave_sel = 2'd0;
        wave_sel_valid = 1'b1;
        @(negedge clk);
        wave_sel_valid = 1'b0;
        chk("sim_strobe", int'(sample_strobe), 1);
        chk("sim_wrap", int'(wrap), 1);
        chk("sim_sample", int'(sample), 255);
        chk("sim_active", int'(active_wave), 0);
        for (int k = 1; k <= 256; k++) wait_strobe(n);
        chk("sim_next_wrap", int'(wrap), 1);
        chk("sim_next_active", int'(active_wave), 0);
        chk("sim_next_sample", int'(sample), 255);

        // 6. divider shrink, mute mid-run, request in mute, pending then reset
        divider = 16'd8;
        for (int k = 1; k <= 37; k++) begin
            wait_strobe(n);
            if (k == 11) begin
                chk("shrink_next_cycle", n, 1);
                divider = 16'd8;
            end
            if (k == 10) begin
                repeat (5) @(negedge clk);
                divider = 16'd2;
            end
        end
        divider = 16'd0;
        @(negedge clk);
        chk("mute_sample", int'(sample), 0);
        chk("mute_strobe", int'(sample_strobe), 0);
        repeat (10) begin
            @(negedge clk);
            chk("mute_no_strobe", int'(sample_strobe), 0);
        end
        pulse(2'd2);
        chk("mute_apply_tri", int'(active_wave), 2);
        divider = 16'd4;
        wait_strobe(n);
        chk("unmute_latency", n, 4);
        chk("unmute_phase1", int'(sample), 2);
        pulse(2'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_discard_active", int'(active_wave), 0);
        chk("rst_mid_sample", int'(sample), 0);
        rst = 1'b0;
        divider = 16'd1;
        for (int k = 1; k <= 256; k++) wait_strobe(n);
        chk("rst_discard_wrap", int'(wrap), 1);
        chk("rst_discard_keep_sq", int'(active_wave), 0);
        chk("rst_discard_sample", int'(sample), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
